// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the bfloat16 operand stage.
//   Classif_e        - operand class carried alongside each buffered operand
//   opstage_state_e  - occupancy state of the operand skid buffer
//   BF16_EXP_MAX     - all-ones bfloat16 exponent (Inf / NaN encodings)
//   BF16_CANON_NAN   - canonical quiet NaN, used when FP_OPSTAGE_CANON_NAN_EN is defined
package ibex_pkg;

  typedef enum logic [2:0] {
    Zero     = 3'd0,
    Sub_Norm = 3'd1,
    Norm     = 3'd2,
    Inf      = 3'd3,
    Neg_Inf  = 3'd4,
    NaN      = 3'd5
  } Classif_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } opstage_state_e;

  localparam logic [7:0]  BF16_EXP_MAX   = 8'hFF;
  localparam logic [15:0] BF16_CANON_NAN = 16'h7FC0;

endpackage

// File: rtl/fp_classifier.sv
// fp_classifier: purely combinational bfloat16 classifier.
//   fp_i     [15:0] - operand {sign, exp[7:0], sig[6:0]}
//   classif_o       - Zero / Sub_Norm / NaN / Inf / Neg_Inf / Norm, in that priority
module fp_classifier
  import ibex_pkg::*;
(
  input  logic [15:0] fp_i,
  output Classif_e    classif_o
);

  logic       sign;
  logic [7:0] exp;
  logic [6:0] sig;

  assign sign = fp_i[15];
  assign exp  = fp_i[14:7];
  assign sig  = fp_i[6:0];

  always_comb begin
    classif_o = Norm;
    if (exp == 8'h00) begin
      classif_o = (sig == 7'h00) ? Zero : Sub_Norm;
    end else if (exp == BF16_EXP_MAX) begin
      if (sig != 7'h00) classif_o = NaN;
      else              classif_o = sign ? Neg_Inf : Inf;
    end
  end

endmodule

// File: rtl/fp_operand_stage.sv
// fp_operand_stage: 2-entry (main + skid) operand buffer in front of a
// bfloat16 converter. Each operand is classified on entry and the class is
// stored with it, so outputs come straight from registers.
//
// Handshake: a transfer happens on a cycle where valid && ready are both high
// at the rising edge; valid, once raised, and its data are held until that
// transfer. in_ready_o and out_valid_o depend on the registered state only.
//
// Ports:
//   clk_i, rst_ni     - clock, synchronous active-low reset
//   flush_i           - drop all buffered operands (beats same-cycle transfers)
//   in_valid_i/in_ready_o/in_fp_i         - upstream operand
//   out_valid_o/out_ready_i/out_fp_o      - downstream operand (main entry)
//   out_classif_o     - class of out_fp_o
//
// Build option: FP_OPSTAGE_CANON_NAN_EN - replace every NaN with 16'h7FC0
// before storage (class stays NaN). Undefined: NaNs pass through unchanged.
module fp_operand_stage
  import ibex_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [15:0]        in_fp_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [15:0]        out_fp_o,
  output ibex_pkg::Classif_e out_classif_o
);

  // Buffer occupancy; kept as a named enum so checkers can bind to it.
  opstage_state_e state_q, state_d;

  logic [15:0] main_fp_q, skid_fp_q;
  Classif_e    main_cls_q, skid_cls_q;

  Classif_e    in_cls;
  logic [15:0] in_fp_store;

  logic accept, out_xfer;
  logic load_main_in, load_main_skid, load_skid_in;

  fp_classifier u_classifier (
    .fp_i      (in_fp_i),
    .classif_o (in_cls)
  );

`ifdef FP_OPSTAGE_CANON_NAN_EN
  assign in_fp_store = (in_cls == NaN) ? BF16_CANON_NAN : in_fp_i;
`else
  assign in_fp_store = in_fp_i;
`endif

  assign accept   = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  // Next state and datapath load enables. Flush cancels every load.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && out_xfer) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d      = ST_FULL;
            load_skid_in = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // No accept possible here: in_ready_o is low.
          if (out_xfer) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs from registered state only
  always_comb begin
    in_ready_o  = (state_q != ST_FULL);
    out_valid_o = (state_q != ST_EMPTY);
  end

  // Operand storage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_fp_q  <= 16'h0000;
      main_cls_q <= Zero;
      skid_fp_q  <= 16'h0000;
      skid_cls_q <= Zero;
    end else begin
      if (load_main_in) begin
        main_fp_q  <= in_fp_store;
        main_cls_q <= in_cls;
      end else if (load_main_skid) begin
        main_fp_q  <= skid_fp_q;
        main_cls_q <= skid_cls_q;
      end
      if (load_skid_in) begin
        skid_fp_q  <= in_fp_store;
        skid_cls_q <= in_cls;
      end
    end
  end

  assign out_fp_o      = main_fp_q;
  assign out_classif_o = main_cls_q;

endmodule
